// File: rtl/dircc_rx_pkg.sv
// -----------------------------------------------------------------------------
// dircc_rx_pkg
// Shared definitions for the DIRCC node receive path:
//   - MEM_DEPTH      : halfword depth of the processing memory's 16-bit port
//   - HDR_* indices  : bit positions inside the per-slot header halfword
//   - rx_state_e     : receive-writer FSM state encoding
//   - make_header()  : packs the truncated flag and payload count into a header
// -----------------------------------------------------------------------------
package dircc_rx_pkg;

    localparam int MEM_DEPTH     = 15000;

    localparam int HDR_TRUNC_BIT = 15;
    localparam int HDR_COUNT_MSB = 14;
    localparam int HDR_COUNT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_HEADER  = 2'd2,
        ST_DROP    = 2'd3
    } rx_state_e;

    function automatic logic [15:0] make_header(input logic       trunc,
                                                input logic [14:0] count);
        logic [15:0] hdr;
        hdr = 16'h0000;
        hdr[HDR_TRUNC_BIT] = trunc;
        hdr[HDR_COUNT_MSB:HDR_COUNT_LSB] = count;
        return hdr;
    endfunction

endpackage

// File: rtl/dircc_slot_ring_ctrl.sv
// -----------------------------------------------------------------------------
// dircc_slot_ring_ctrl
// Ring bookkeeping for the receive slots: the write head (next slot to fill),
// the read slot (oldest full slot) and the count of full slots.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   i_commit      : one-cycle pulse, a header has been written to the head slot
//   i_release     : one-cycle pulse from the CPU freeing the oldest full slot
//   o_head        : slot index the writer fills next
//   o_rd_slot     : index of the oldest full slot
//   o_rx_count    : number of full slots (0..NUM_SLOTS)
//   o_irq         : high while o_rx_count != 0
// -----------------------------------------------------------------------------
module dircc_slot_ring_ctrl #(
    parameter int NUM_SLOTS = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_commit,
    input  logic                         i_release,
    output logic [$clog2(NUM_SLOTS)-1:0] o_head,
    output logic [$clog2(NUM_SLOTS)-1:0] o_rd_slot,
    output logic [$clog2(NUM_SLOTS):0]   o_rx_count,
    output logic                         o_irq
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);

    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [SLOT_W:0]   cnt_t;

    localparam slot_t SLOT_ONE = slot_t'(32'd1);
    localparam cnt_t  CNT_ONE  = cnt_t'(32'd1);
    localparam cnt_t  CNT_ZERO = cnt_t'(32'd0);

    slot_t r_head;
    slot_t r_rd_slot;
    cnt_t  r_count;
    logic  r_irq;

    logic  w_rel_ok;
    cnt_t  w_count_nxt;

    // A release with no full slot would underflow the ring, so it is ignored.
    always_comb begin
        w_rel_ok = i_release & (r_count != CNT_ZERO);
    end

    // Full-slot count: a commit and a valid release in the same cycle cancel.
    always_comb begin
        w_count_nxt = r_count;
        if (i_commit && !w_rel_ok) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!i_commit && w_rel_ok) begin
            w_count_nxt = r_count - CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Ring pointers, count and interrupt; pointers wrap naturally (power of 2).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head    <= {SLOT_W{1'b0}};
            r_rd_slot <= {SLOT_W{1'b0}};
            r_count   <= CNT_ZERO;
            r_irq     <= 1'b0;
        end else begin
            if (i_commit) begin
                r_head <= r_head + SLOT_ONE;
            end else begin
                r_head <= r_head;
            end
            if (w_rel_ok) begin
                r_rd_slot <= r_rd_slot + SLOT_ONE;
            end else begin
                r_rd_slot <= r_rd_slot;
            end
            r_count <= w_count_nxt;
            r_irq   <= (w_count_nxt != CNT_ZERO);
        end
    end

    assign o_head     = r_head;
    assign o_rd_slot  = r_rd_slot;
    assign o_rx_count = r_count;
    assign o_irq      = r_irq;

endmodule

// File: rtl/dircc_node_rx_writer.sv
// -----------------------------------------------------------------------------
// dircc_node_rx_writer
// Writes incoming packets into a ring of fixed-size slots in the processing
// memory. Each slot holds a one-halfword header (truncated flag + payload
// count) at offset 0 followed by payload from offset 1. Packets that arrive
// while every slot is full are dropped and counted.
// Ports:
//   clk, reset_n                      : clock, synchronous active-low reset
//   in_data/in_valid/in_sop/in_eop    : packet beat stream
//   in_ready                          : beat accepted when in_valid & in_ready
//   mem_*                             : registered write port to the memory
//   slot_release                      : CPU pulse freeing the oldest full slot
//   rd_slot, rx_count, drop_count, irq: status towards the CPU
// -----------------------------------------------------------------------------
module dircc_node_rx_writer
    import dircc_rx_pkg::*;
#(
    parameter int BASE_ADDR  = 14000,
    parameter int SLOT_WORDS = 64,
    parameter int NUM_SLOTS  = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [15:0]                  in_data,
    input  logic                         in_valid,
    input  logic                         in_sop,
    input  logic                         in_eop,
    output logic                         in_ready,
    output logic [13:0]                  mem_address,
    output logic [15:0]                  mem_writedata,
    output logic [1:0]                   mem_byteenable,
    output logic                         mem_chipselect,
    output logic                         mem_write,
    output logic                         mem_clken,
    input  logic                         slot_release,
    output logic [$clog2(NUM_SLOTS)-1:0] rd_slot,
    output logic [$clog2(NUM_SLOTS):0]   rx_count,
    output logic [15:0]                  drop_count,
    output logic                         irq
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int OFF_W  = $clog2(SLOT_WORDS);

    if (BASE_ADDR + NUM_SLOTS * SLOT_WORDS > MEM_DEPTH) begin : g_bad_range
        $error("dircc_node_rx_writer: slot ring exceeds memory depth");
    end
    if ((SLOT_WORDS < 4) || ((SLOT_WORDS & (SLOT_WORDS - 1)) != 0)) begin : g_bad_slot_words
        $error("dircc_node_rx_writer: SLOT_WORDS must be a power of 2 >= 4");
    end
    if ((NUM_SLOTS < 2) || (NUM_SLOTS > 64) || ((NUM_SLOTS & (NUM_SLOTS - 1)) != 0)) begin : g_bad_num_slots
        $error("dircc_node_rx_writer: NUM_SLOTS must be a power of 2 in 2..64");
    end

    typedef logic [OFF_W-1:0] off_t;
    // One bit wider than an offset so "slot full" (== SLOT_WORDS) is representable.
    typedef logic [OFF_W:0]   ptr_t;
    typedef logic [SLOT_W:0]  cnt_t;

    localparam off_t OFF_ZERO   = off_t'(32'd0);
    localparam off_t OFF_ONE    = off_t'(32'd1);
    localparam ptr_t PTR_ZERO   = ptr_t'(32'd0);
    localparam ptr_t PTR_ONE    = ptr_t'(32'd1);
    localparam ptr_t PTR_TWO    = ptr_t'(32'd2);
    localparam ptr_t SLOT_END   = ptr_t'(SLOT_WORDS);
    localparam cnt_t FULL_COUNT = cnt_t'(NUM_SLOTS);

    rx_state_e           r_state;
    ptr_t                r_wr_off;
    logic                r_trunc;
    logic [15:0]         r_drop;
    logic [13:0]         r_mem_addr;
    logic [15:0]         r_mem_data;
    logic [1:0]          r_mem_be;
    logic                r_mem_wr;

    rx_state_e           w_state_nxt;
    ptr_t                w_off_nxt;
    logic                w_trunc_nxt;
    logic                w_drop_inc;
    logic                w_commit;
    logic                w_wr_en;
    off_t                w_wr_off;
    logic [15:0]         w_wr_data;
    logic [13:0]         w_wr_addr;
    logic                w_accept;
    logic                w_full;
    ptr_t                w_pl_count;
    logic [SLOT_W-1:0]   w_head;

    dircc_slot_ring_ctrl #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_ring (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_commit   (w_commit),
        .i_release  (slot_release),
        .o_head     (w_head),
        .o_rd_slot  (rd_slot),
        .o_rx_count (rx_count),
        .o_irq      (irq)
    );

    // Ready everywhere except the single header-write cycle, and never in reset.
    always_comb begin
        if (!reset_n) begin
            in_ready = 1'b0;
        end else if (r_state == ST_HEADER) begin
            in_ready = 1'b0;
        end else begin
            in_ready = 1'b1;
        end
    end

    // Handshake, fullness and payload count derived from current state.
    always_comb begin
        w_accept   = in_valid & in_ready;
        w_full     = (rx_count == FULL_COUNT);
        w_pl_count = r_wr_off - PTR_ONE;
    end

    // Receive FSM: decides the write for this cycle and the next-state values.
    always_comb begin
        w_state_nxt = r_state;
        w_off_nxt   = r_wr_off;
        w_trunc_nxt = r_trunc;
        w_drop_inc  = 1'b0;
        w_commit    = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_off    = r_wr_off[OFF_W-1:0];
        w_wr_data   = in_data;
        case (r_state)
            ST_IDLE: begin
                // Fullness is judged here only; an accepted packet always completes.
                if (w_accept && in_sop) begin
                    if (!w_full) begin
                        w_wr_en     = 1'b1;
                        w_wr_off    = OFF_ONE;
                        w_off_nxt   = PTR_TWO;
                        w_trunc_nxt = 1'b0;
                        w_state_nxt = in_eop ? ST_HEADER : ST_PAYLOAD;
                    end else begin
                        w_drop_inc  = 1'b1;
                        w_state_nxt = in_eop ? ST_IDLE : ST_DROP;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (w_accept) begin
                    if (in_sop) begin
                        // A new start mid-packet closes the current one; the beat is lost.
                        w_trunc_nxt = 1'b1;
                        w_state_nxt = ST_HEADER;
                    end else begin
                        if (r_wr_off != SLOT_END) begin
                            w_wr_en   = 1'b1;
                            w_off_nxt = r_wr_off + PTR_ONE;
                        end else begin
                            w_trunc_nxt = 1'b1;
                        end
                        w_state_nxt = in_eop ? ST_HEADER : ST_PAYLOAD;
                    end
                end else begin
                    w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_HEADER: begin
                w_wr_en     = 1'b1;
                w_wr_off    = OFF_ZERO;
                w_wr_data   = make_header(r_trunc, 15'(w_pl_count));
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_DROP: begin
                if (w_accept && in_eop) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Slot base plus offset; both sizes are powers of two so this is a concat.
    always_comb begin
        w_wr_addr = 14'(BASE_ADDR) + 14'({w_head, w_wr_off});
    end

    // FSM state, write offset, truncated flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_wr_off <= PTR_ZERO;
            r_trunc  <= 1'b0;
            r_drop   <= 16'h0000;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_off <= w_off_nxt;
            r_trunc  <= w_trunc_nxt;
            if (w_drop_inc && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'h0001;
            end else begin
                r_drop <= r_drop;
            end
        end
    end

    // Registered memory port; address/data hold between writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mem_addr <= 14'h0000;
            r_mem_data <= 16'h0000;
            r_mem_be   <= 2'b00;
            r_mem_wr   <= 1'b0;
        end else if (w_wr_en) begin
            r_mem_addr <= w_wr_addr;
            r_mem_data <= w_wr_data;
            r_mem_be   <= 2'b11;
            r_mem_wr   <= 1'b1;
        end else begin
            r_mem_wr   <= 1'b0;
        end
    end

    assign mem_address    = r_mem_addr;
    assign mem_writedata  = r_mem_data;
    assign mem_byteenable = r_mem_be;
    assign mem_write      = r_mem_wr;
    assign mem_chipselect = r_mem_wr;
    assign mem_clken      = 1'b1;
    assign drop_count     = r_drop;

endmodule

// File: tb/tb_dircc_node_rx_writer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dircc_node_rx_writer
// Directed scenarios followed by randomized packet traffic. A packet-level
// reference model predicts every memory write and the status counters.
// -----------------------------------------------------------------------------
module tb_dircc_node_rx_writer;

    localparam int BASE = 14000;
    localparam int SW   = 64;
    localparam int NS   = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic        in_ready;
    logic [13:0] mem_address;
    logic [15:0] mem_writedata;
    logic [1:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic        mem_clken;
    logic        slot_release = 1'b0;
    logic [2:0]  rd_slot;
    logic [3:0]  rx_count;
    logic [15:0] drop_count;
    logic        irq;

    always #5 clk = ~clk;

    dircc_node_rx_writer #(
        .BASE_ADDR  (BASE),
        .SLOT_WORDS (SW),
        .NUM_SLOTS  (NS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_clken      (mem_clken),
        .slot_release   (slot_release),
        .rd_slot        (rd_slot),
        .rx_count       (rx_count),
        .drop_count     (drop_count),
        .irq            (irq)
    );

    typedef struct { int addr; logic [15:0] data; } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_head = 0, m_rd = 0, m_count = 0, m_drop = 0;
    logic [15:0] pkt_d [0:127];
    int          pkt_len = 0;
    int          pkt_mid = -1;
    int          last_stalls = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every write on the memory port must be the next one the model predicts.
    always @(negedge clk) begin : mon
        wr_t e;
        if (mem_write || mem_chipselect) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_wr", 32'(mem_write), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_addr", 32'(mem_address), 32'(e.addr));
                check_eq("wr_data", 32'(mem_writedata), 32'(e.data));
                check_eq("wr_be", 32'(mem_byteenable), 32'd3);
                check_eq("wr_cs", 32'(mem_chipselect & mem_write), 32'd1);
                check_eq("wr_clken", 32'(mem_clken), 32'd1);
            end
        end
    end

    task automatic model_clear();
        m_head = 0; m_rd = 0; m_count = 0; m_drop = 0;
        exp_q.delete();
    endtask

    task automatic model_packet(input bit stored, input bit do_rel);
        int avail, nstore, base;
        bit trunc;
        wr_t e;
        if (!stored) begin
            if (m_drop < 65535) m_drop++;
        end else begin
            avail  = (pkt_mid > 0) ? pkt_mid : pkt_len;
            nstore = (avail < SW - 1) ? avail : SW - 1;
            trunc  = (pkt_mid > 0) || (pkt_len > SW - 1);
            base   = BASE + m_head * SW;
            for (int i = 0; i < nstore; i++) begin
                e.addr = base + 1 + i;
                e.data = pkt_d[i];
                exp_q.push_back(e);
            end
            e.addr = base;
            e.data = 16'(nstore) + (trunc ? 16'h8000 : 16'h0000);
            exp_q.push_back(e);
            m_head = (m_head + 1) % NS;
            if (do_rel && m_count > 0) m_rd = (m_rd + 1) % NS;
            else m_count++;
        end
    endtask

    task automatic check_state();
        check_eq("rx_count", 32'(rx_count), 32'(m_count));
        check_eq("rd_slot", 32'(rd_slot), 32'(m_rd));
        check_eq("drop_count", 32'(drop_count), 32'(m_drop));
        check_eq("irq", 32'(irq), 32'(m_count != 0));
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic drive_beat(input logic [15:0] d, input bit sop, input bit eop, output int stalls);
        in_data = d; in_sop = sop; in_eop = eop; in_valid = 1'b1;
        stalls = 0;
        #1;
        while (!in_ready && stalls < 20) begin
            @(negedge clk); #1;
            stalls++;
        end
        if (!in_ready) check_eq("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_packet(input bit rel_at_hdr, input bit bubbles);
        bit stored, do_rel;
        int st;
        stored = (m_count < NS);
        do_rel = rel_at_hdr && stored && (pkt_mid < 0);
        model_packet(stored, do_rel);
        last_stalls = 0;
        for (int i = 0; i < pkt_len; i++) begin
            if (bubbles && $urandom_range(3, 0) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            drive_beat(pkt_d[i], (i == 0) || (i == pkt_mid), i == pkt_len - 1, st);
            last_stalls += st;
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        if (stored && pkt_mid < 0) begin
            #1;
            check_eq("hdr_ready", 32'(in_ready), 32'd0);
            if (do_rel) begin
                slot_release = 1'b1;
                @(negedge clk);
                slot_release = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_release();
        slot_release = 1'b1;
        if (m_count > 0) begin
            m_count--;
            m_rd = (m_rd + 1) % NS;
        end
        @(negedge clk);
        slot_release = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        check_eq("wr_q_drained", 32'(exp_q.size()), 32'd0);
        reset_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic fill_random(input int len);
        pkt_len = len;
        pkt_mid = -1;
        for (int i = 0; i < len; i++) pkt_d[i] = 16'($urandom);
    endtask

    initial begin : stim
        wr_t e;
        int st;
        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_mem_wr", 32'(mem_write), 32'd0);
        check_eq("rst_mem_cs", 32'(mem_chipselect), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_address), 32'd0);
        check_eq("rst_mem_data", 32'(mem_writedata), 32'd0);
        check_eq("rst_mem_be", 32'(mem_byteenable), 32'd0);
        check_eq("rst_clken", 32'(mem_clken), 32'd1);
        model_clear();
        check_state();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset during beat 2 abandons the packet
        e.addr = BASE + 1; e.data = 16'h0B01;
        exp_q.push_back(e);
        drive_beat(16'h0B01, 1'b1, 1'b0, st);
        in_data = 16'h0B02; in_sop = 1'b0; reset_n = 1'b0;
        #1;
        check_eq("midrst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; in_valid = 1'b0;
        check_eq("midrst_q", 32'(exp_q.size()), 32'd0);
        model_clear();
        repeat (3) @(negedge clk);
        check_state();

        // Three-beat packet into slot 0
        pkt_len = 3; pkt_mid = -1;
        pkt_d[0] = 16'h00A1; pkt_d[1] = 16'h00A2; pkt_d[2] = 16'h00A3;
        send_packet(1'b0, 1'b0);
        check_eq("a3_rx_count", 32'(rx_count), 32'd1);
        check_eq("a3_irq", 32'(irq), 32'd1);
        check_state();
        do_release();
        check_state();

        // 70-beat packet truncated to 63 halfwords
        reset_dut();
        pkt_len = 70; pkt_mid = -1;
        for (int i = 0; i < 70; i++) pkt_d[i] = 16'(16'h7000 + i);
        send_packet(1'b0, 1'b0);
        check_state();

        // Eight packets fill the ring, ninth is dropped without stalling
        reset_dut();
        for (int p = 0; p < 8; p++) begin
            fill_random($urandom_range(6, 1));
            send_packet(1'b0, 1'b1);
        end
        fill_random(5);
        send_packet(1'b0, 1'b0);
        check_eq("drop_stalls", 32'(last_stalls), 32'd0);
        check_eq("drop_count_1", 32'(drop_count), 32'd1);
        check_eq("full_rx_count", 32'(rx_count), 32'd8);
        check_state();
        // One release, then the next packet wraps into slot 0
        do_release();
        fill_random(4);
        send_packet(1'b0, 1'b0);
        check_eq("wrap_rx_count", 32'(rx_count), 32'd8);
        check_state();

        // Header commit coinciding with a release, rx_count = 3
        reset_dut();
        for (int p = 0; p < 3; p++) begin
            fill_random(2);
            send_packet(1'b0, 1'b0);
        end
        fill_random(3);
        send_packet(1'b1, 1'b0);
        check_eq("coinc_rx_count", 32'(rx_count), 32'd3);
        check_eq("coinc_rd_slot", 32'(rd_slot), 32'd1);
        check_state();

        // Start-of-packet inside a packet closes it with the truncated flag
        fill_random(6);
        pkt_mid = 3;
        send_packet(1'b0, 1'b0);
        check_state();

        // Randomized traffic
        for (int it = 0; it < 150; it++) begin
            int action;
            action = $urandom_range(9, 0);
            if (action < 3) begin
                do_release();
            end else if (action == 3) begin
                drive_beat(16'($urandom), 1'b0, 1'($urandom_range(1, 0)), st);
                in_valid = 1'b0;
                repeat (2) @(negedge clk);
            end else begin
                fill_random($urandom_range(80, 1));
                if (pkt_len > 2 && $urandom_range(7, 0) == 0)
                    pkt_mid = $urandom_range(pkt_len - 1, 1);
                send_packet(1'($urandom_range(3, 0) == 0), 1'b1);
            end
            check_state();
        end

        repeat (3) @(negedge clk);
        check_eq("wr_q_final", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dircc_node_rx_writer.md
DIRCC_NODE_RX_WRITER -- requirements
Module: dircc_node_rx_writer

Interface
REQ-001 Parameters SHALL be: BASE_ADDR, 14000, halfword address of slot 0 in the processing memory's 16-bit port.
REQ-002 Parameters (cont.): SLOT_WORDS, 64, halfwords per slot (power of 2, >= 4); NUM_SLOTS, 8, slot count (power of 2, 2..64).
REQ-003 Parameter constraint SHALL hold: BASE_ADDR + NUM_SLOTS*SLOT_WORDS <= 15000; violation is an elaboration error.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_n  in  1  reset; synchronous and active-low.
REQ-006 in_data  in  16  packet halfword; in_valid  in  1  beat valid; in_sop  in  1  first beat; in_eop  in  1  last beat.
REQ-007 in_ready  out  1  beat accepted when in_valid & in_ready at a rising edge.
REQ-008 mem_address  out  14; mem_writedata  out  16; mem_byteenable  out  2; mem_chipselect, mem_write, mem_clken  out  1 each: drive the memory's second port.
REQ-009 slot_release  in  1  one-cycle pulse from the CPU freeing the oldest full slot.
REQ-010 rd_slot  out  log2(NUM_SLOTS)  index of the oldest full slot; rx_count  out  log2(NUM_SLOTS)+1  full slots; drop_count  out  16  dropped packets; irq  out  1  high while rx_count != 0.

Function
REQ-011 Slot k SHALL occupy halfwords BASE_ADDR+k*SLOT_WORDS .. +SLOT_WORDS-1; offset 0 is the header, payload starts at offset 1.
REQ-012 Header SHALL be: bit15 truncated flag, bits14:0 payload halfwords stored.
REQ-013 FSM states SHALL be IDLE, PAYLOAD, HEADER, DROP.
REQ-014 IDLE: in_ready=1; beat with in_sop & rx_count<NUM_SLOTS -> write to offset 1, go PAYLOAD (or HEADER if in_eop); in_sop & full -> drop_count+1, go DROP (stay IDLE if in_eop); beat without in_sop -> discarded, no count.
REQ-015 PAYLOAD: in_ready=1; each beat written to next offset; at offset SLOT_WORDS-1 written, further beats are discarded and truncated flag set; in_eop -> HEADER.
REQ-016 PAYLOAD: beat with in_sop SHALL close the current packet (go HEADER, truncated flag set) and that beat is discarded.
REQ-017 HEADER: in_ready=0 for exactly one cycle; header written to offset 0; head index +1 modulo NUM_SLOTS; next state IDLE.
REQ-018 DROP: in_ready=1, beats discarded until in_eop accepted -> IDLE.
REQ-019 Memory outputs SHALL be registered: a beat accepted at edge N is on the port during cycle N+1 with mem_chipselect=mem_write=1, mem_byteenable=2'b11.
REQ-020 mem_clken SHALL be constant 1; mem_write and mem_chipselect SHALL be 0 in every cycle without a write.
REQ-021 rx_count SHALL increment at the edge ending the header write; rd_slot and rx_count SHALL decrement/advance (rd_slot modulo NUM_SLOTS) on slot_release.
REQ-022 Simultaneous header commit and slot_release SHALL leave rx_count unchanged and advance rd_slot.
REQ-023 slot_release with rx_count=0 SHALL be ignored.
REQ-024 Fullness SHALL be sampled only on the sop beat; a packet in progress always completes.
REQ-025 drop_count SHALL saturate at 16'hFFFF.

Reset
REQ-026 On a clock edge with reset_n=0: state IDLE, head/rd_slot 0, rx_count 0, drop_count 0, irq 0, mem_write/mem_chipselect 0, mem_address 0, mem_writedata 0, mem_byteenable 0; in_ready=0 while reset_n=0.
REQ-027 Reset mid-packet SHALL abandon the packet without writing its header; memory contents are not cleared.

Structure
REQ-028 Package dircc_rx_pkg SHALL hold the FSM state enum, header bit positions and the 15000-halfword memory-depth constant.
REQ-029 One sub-module, dircc_slot_ring_ctrl, SHALL hold head/rd_slot/rx_count and the release/commit arithmetic.

Verification
REQ-030 Defaults, 3-beat packet 0xA1,0xA2,0xA3 -> writes 14001..14003, then header 0x0003 at 14000, rx_count=1, irq=1.
REQ-031 70-beat packet -> 63 payload writes (14001..14063), header 0x803F, no write beyond 14063.
REQ-032 8 packets, no releases, 9th packet -> no memory writes, drop_count=1, in_ready stays 1 through its eop.
REQ-033 Header commit and slot_release in the same cycle with rx_count=3 -> rx_count=3, rd_slot +1.
REQ-034 9 packets with one release in between -> 9th packet's header at 14000 (slot 0 reused after wrap).
REQ-035 reset_n low for one edge during beat 2 of a packet -> no header write, rx_count=0, next packet lands in slot 0.
